memwb_elastic_stage: RTL and testbench
======================================

// Module: memwb_elastic_stage
// PURPOSE
//  Parametrised MEM/WB pipeline boundary: 2-entry skid buffer with valid/ready handshakes on both sides,
//  debug single-step gating, flush (squash), sticky halt detection and a saturating retire counter.
//  Sits between the MEM stage and the write-back mux/register file. Payload is an opaque packed vector.
//  Field offsets come from the shared package.
// PARAMETERS
//  PAYLOAD_W  142  width of packed MEM/WB payload (pc8, instr, alu, mem data, ext, rd, WB controls)
//  HALT_BIT   0    payload bit index of the halt control flag
//  WE_BIT     1    payload bit index of the register-write control flag
//  CNT_W      32   width of retire counter
// PORTS
//  i_clk        in   1          clock
//  i_reset      in   1          synchronous, active-high reset
//  i_step       in   1          global advance enable (debug step / run); 0 freezes all state except flush
//  i_flush      in   1          squash every held entry
//  i_valid      in   1          upstream payload valid
//  o_ready      out  1          stage can accept (registered)
//  i_payload    in   PAYLOAD_W  upstream payload
//  o_valid      out  1          main entry valid
//  i_ready      in   1          downstream (WB) accepts
//  o_payload    out  PAYLOAD_W  main-entry payload
//  o_wb_we      out  1          o_valid & o_payload[WE_BIT]; the only legal RF write enable
//  o_halted     out  1          sticky: a halt-flagged entry has retired
//  o_retired    out  CNT_W      count of retired entries, saturating
//  o_occupancy  out  2          entries held: 0, 1 or 2
// BEHAVIOUR
//  Reset: both entry valids=0, both payload regs=0, o_ready=1, o_valid=0, o_wb_we=0, o_halted=0,
//   o_retired=0, o_occupancy=0.
//  Accept (acc) = i_valid & o_ready & i_step. Retire (ret) = o_valid & i_ready & i_step.
//  o_ready = ~skid_valid & ~o_halted, from registers only (no i_ready->o_ready comb path).
//  States:
//   EMPTY: acc -> ONE (main<=in).
//   ONE: acc&ret -> ONE (main<=in). acc&~ret -> FULL (skid<=in). ret only -> EMPTY.
//   FULL: no acc possible. ret -> ONE (main<=skid).
//  Ordering strictly FIFO. Latency in->out is 1 cycle when empty. Throughput is 1/cycle with i_ready=1.
//  i_step=0: no transfer, no state, payload or counter change. Upstream must hold i_valid/i_payload.
//  i_flush (step-independent, highest priority): next cycle both valids=0, o_wb_we=0.
//   Payload regs keep their value. Same-cycle acc/ret discarded and not counted.
//   o_halted and o_retired are unaffected.
//  Halt: ret with o_payload[HALT_BIT]=1 sets o_halted next cycle. o_ready is then held 0 until reset.
//   An entry already in skid may still retire.
//  o_retired: +1 per ret. Holds at 2^CNT_W-1 (no wrap).
//  Reset mid-operation: all state returns to reset values next edge, regardless of step/flush.
// STRUCTURE
//  Package mips_pipe_pkg: MEMWB_* field LSB/width localparams, PAYLOAD_W,
//   stage_state_t {ST_EMPTY, ST_ONE, ST_FULL}.
//  Sub-module sat_counter (CNT_W, inc, clr, q), reusable by the other stage boundaries.
//  Stage logic (state register, main/skid regs, halt flag) stays in this module.
// TESTING
//  1 Reset, step=1, i_ready=1, 4 back-to-back payloads A..D -> out A..D on cycles 1..4, o_retired=4,
//    occupancy never >1.
//  2 Fill with i_ready=0: send A,B -> occupancy=2, o_ready=0. Raise i_ready -> A then B, o_ready=1
//    one cycle after A retires.
//  3 step=0 for 5 cycles with i_valid=1, i_ready=1 -> outputs and counter frozen.
//    step=1 -> flow resumes with nothing lost or duplicated.
//  4 FULL + i_flush with i_ready=1 -> next cycle o_valid=0, o_wb_we=0, o_retired unchanged,
//    o_ready=1, payload regs unchanged.
//  5 Retire entry with HALT_BIT=1 while skid holds X -> o_halted=1, X still retires, o_ready stays 0.
//    Reset clears all.
//  6 CNT_W=3: 9 retirements -> o_retired saturates at 7.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared MEM/WB payload layout and stage-boundary types
// Field map of the packed MEM/WB payload (LSB first):
//   ctrl[3:0]  halt, reg write, mem-to-reg, link
//   ext[4:0]   load extension / sub-op selector
//   rd[4:0]    destination register
//   mem data, alu result, instr, pc+8 (32 bits each)
package mips_pipe_pkg;

  localparam int MEMWB_CTRL_LSB      = 0;
  localparam int MEMWB_CTRL_W        = 4;
  localparam int MEMWB_HALT_BIT      = MEMWB_CTRL_LSB + 0;
  localparam int MEMWB_WE_BIT        = MEMWB_CTRL_LSB + 1;
  localparam int MEMWB_MEMTOREG_BIT  = MEMWB_CTRL_LSB + 2;
  localparam int MEMWB_LINK_BIT      = MEMWB_CTRL_LSB + 3;

  localparam int MEMWB_EXT_LSB       = MEMWB_CTRL_LSB + MEMWB_CTRL_W;
  localparam int MEMWB_EXT_W         = 5;
  localparam int MEMWB_RD_LSB        = MEMWB_EXT_LSB + MEMWB_EXT_W;
  localparam int MEMWB_RD_W          = 5;
  localparam int MEMWB_MEMD_LSB      = MEMWB_RD_LSB + MEMWB_RD_W;
  localparam int MEMWB_MEMD_W        = 32;
  localparam int MEMWB_ALU_LSB       = MEMWB_MEMD_LSB + MEMWB_MEMD_W;
  localparam int MEMWB_ALU_W         = 32;
  localparam int MEMWB_INSTR_LSB     = MEMWB_ALU_LSB + MEMWB_ALU_W;
  localparam int MEMWB_INSTR_W       = 32;
  localparam int MEMWB_PC8_LSB       = MEMWB_INSTR_LSB + MEMWB_INSTR_W;
  localparam int MEMWB_PC8_W         = 32;

  localparam int PAYLOAD_W           = MEMWB_PC8_LSB + MEMWB_PC8_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  function automatic logic [1:0] state_occupancy(input stage_state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_ONE:  occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Ports:
//   clk  clock
//   clr  synchronous clear (highest priority)
//   inc  add one unless already at all-ones
//   q    count value
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/memwb_elastic_stage.sv
// rtl/memwb_elastic_stage.sv - MEM/WB 2-entry skid buffer with step gating, flush, halt and retire count
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_step              advance enable; 0 freezes everything except flush
//   i_flush             squash all held entries (step-independent)
//   i_valid/o_ready     upstream handshake, i_payload carried in
//   o_valid/i_ready     downstream handshake, o_payload is the main entry
//   o_wb_we             register-file write enable for the main entry
//   o_halted            sticky: a halt-flagged entry has retired
//   o_retired           saturating retire count
//   o_occupancy         number of held entries (0..2)
module memwb_elastic_stage #(
  parameter int PAYLOAD_W = mips_pipe_pkg::PAYLOAD_W,
  parameter int HALT_BIT  = mips_pipe_pkg::MEMWB_HALT_BIT,
  parameter int WE_BIT    = mips_pipe_pkg::MEMWB_WE_BIT,
  parameter int CNT_W     = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic                 o_wb_we,
  output logic                 o_halted,
  output logic [CNT_W-1:0]     o_retired,
  output logic [1:0]           o_occupancy
);

  import mips_pipe_pkg::*;

  stage_state_t         state;
  stage_state_t         state_nxt;
  logic [PAYLOAD_W-1:0] main_q;
  logic [PAYLOAD_W-1:0] skid_q;
  logic                 halted_q;

  logic main_valid;
  logic skid_valid;
  logic acc;
  logic ret;
  logic ret_commit;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Entry valids are decoded from the state register, so o_ready depends
  // only on flops and never on i_ready.
  assign main_valid = (state != ST_EMPTY);
  assign skid_valid = (state == ST_FULL);
  assign o_ready    = ~skid_valid & ~halted_q;

  assign acc = i_valid & o_ready & i_step;
  assign ret = main_valid & i_ready & i_step;

  // A retirement coinciding with a flush is discarded: it neither counts
  // nor can raise the halt flag.
  assign ret_commit = ret & ~i_flush;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (acc) begin
          state_nxt    = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc && ret) begin
          load_main_in = 1'b1;
        end else if (acc) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (ret) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (ret) begin
          state_nxt      = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush empties the stage but leaves the payload registers untouched.
    if (i_flush) begin
      state_nxt      = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= ST_EMPTY;
      halted_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ret_commit && main_q[HALT_BIT]) begin
        halted_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= i_payload;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= i_payload;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_retire_cnt (
    .clk (i_clk),
    .clr (i_reset),
    .inc (ret_commit),
    .q   (o_retired)
  );

  assign o_valid     = main_valid;
  assign o_payload   = main_q;
  assign o_wb_we     = main_valid & main_q[WE_BIT];
  assign o_halted    = halted_q;
  assign o_occupancy = state_occupancy(state);

endmodule

// File: tb/tb_memwb_elastic_stage.sv
// tb/tb_memwb_elastic_stage.sv - self-checking bench for memwb_elastic_stage
module tb_memwb_elastic_stage;
  import mips_pipe_pkg::*;

  localparam int PW = PAYLOAD_W;
  localparam int HB = MEMWB_HALT_BIT;
  localparam int WB = MEMWB_WE_BIT;

  logic          i_clk = 1'b0;
  logic          i_reset, i_step, i_flush, i_valid, i_ready;
  logic [PW-1:0] i_payload;

  logic          o_ready, o_valid, o_wb_we, o_halted;
  logic [PW-1:0] o_payload;
  logic [31:0]   o_retired;
  logic [1:0]    o_occupancy;

  logic          s_ready, s_valid, s_wb_we, s_halted;
  logic [PW-1:0] s_payload;
  logic [2:0]    s_retired;
  logic [1:0]    s_occupancy;

  always #5 i_clk = ~i_clk;

  memwb_elastic_stage #(.CNT_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_payload(i_payload),
    .o_valid(o_valid), .i_ready(i_ready), .o_payload(o_payload),
    .o_wb_we(o_wb_we), .o_halted(o_halted), .o_retired(o_retired),
    .o_occupancy(o_occupancy)
  );

  memwb_elastic_stage #(.CNT_W(3)) dut_sat (
    .i_clk(i_clk), .i_reset(i_reset), .i_step(i_step), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(s_ready), .i_payload(i_payload),
    .o_valid(s_valid), .i_ready(i_ready), .o_payload(s_payload),
    .o_wb_we(s_wb_we), .o_halted(s_halted), .o_retired(s_retired),
    .o_occupancy(s_occupancy)
  );

  // Reference model: an in-order queue of held payloads plus flags.
  logic [PW-1:0] m_q[$];
  logic [PW-1:0] m_last;
  bit            m_halted;
  longint        m_count;
  bit            m_acc;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_payload(input bit halt, input bit we);
    logic [159:0] r;
    logic [PW-1:0] p;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    p = r[PW-1:0];
    p[HB] = halt;
    p[WB] = we;
    return p;
  endfunction

  task automatic model_edge();
    bit rdy, acc, ret;
    logic [PW-1:0] head;
    rdy = (m_q.size() < 2) && !m_halted;
    acc = i_valid && rdy && i_step;
    ret = (m_q.size() > 0) && i_ready && i_step;
    m_acc = 1'b0;
    if (i_reset) begin
      m_q.delete();
      m_halted = 1'b0;
      m_count  = 0;
      m_last   = '0;
    end else if (i_flush) begin
      m_q.delete();
    end else begin
      if (ret) begin
        head = m_q.pop_front();
        m_count++;
        if (head[HB]) m_halted = 1'b1;
      end
      if (acc) begin
        m_q.push_back(i_payload);
        m_acc = 1'b1;
      end
      if (m_q.size() > 0) m_last = m_q[0];
    end
  endtask

  task automatic check_all();
    bit            ev;
    logic [PW-1:0] ep;
    longint        es;
    ev = (m_q.size() > 0);
    ep = ev ? m_q[0] : m_last;
    es = (m_count > 7) ? 7 : m_count;
    chk("valid",     o_valid, ev);
    chk("payload",   o_payload, ep);
    chk("ready",     o_ready, (m_q.size() < 2) && !m_halted);
    chk("occupancy", o_occupancy, m_q.size());
    chk("wb_we",     o_wb_we, ev && ep[WB]);
    chk("halted",    o_halted, m_halted);
    chk("retired",   o_retired, m_count[31:0]);
    chk("sat_retired", s_retired, es[2:0]);
  endtask

  task automatic cycle();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    check_all();
  endtask

  logic [PW-1:0] pl[0:8];
  logic [PW-1:0] pa, px;
  logic [31:0]   r0;

  initial begin
    m_last = '0; m_halted = 1'b0; m_count = 0; m_acc = 1'b0;
    i_reset = 1'b1; i_step = 1'b1; i_flush = 1'b0;
    i_valid = 1'b0; i_ready = 1'b1; i_payload = '0;

    // Reset state
    cycle(); cycle();
    i_reset = 1'b0;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_wb_we", o_wb_we, 1'b0);
    chk("rst_halted", o_halted, 1'b0);
    chk("rst_retired", o_retired, 32'd0);
    chk("rst_occ", o_occupancy, 2'd0);
    chk("rst_payload", o_payload, {PW{1'b0}});

    // 1: back-to-back stream A..D
    for (int k = 0; k < 9; k++) pl[k] = rand_payload(1'b0, k[0]);
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_payload = pl[k];
      cycle();
      chk("t1_out", o_payload, pl[k]);
      chk("t1_vld", o_valid, 1'b1);
      chk("t1_occ_le1", o_occupancy <= 2'd1, 1'b1);
    end
    i_valid = 1'b0;
    cycle();
    chk("t1_retired", o_retired, 32'd4);
    chk("t1_occ_end", o_occupancy, 2'd0);

    // 2: fill with downstream stalled, then drain
    i_ready = 1'b0;
    i_valid = 1'b1; i_payload = pl[4]; cycle();
    i_valid = 1'b1; i_payload = pl[5]; cycle();
    chk("t2_occ_full", o_occupancy, 2'd2);
    chk("t2_ready_full", o_ready, 1'b0);
    chk("t2_head_a", o_payload, pl[4]);
    i_valid = 1'b0; i_ready = 1'b1;
    cycle();
    chk("t2_head_b", o_payload, pl[5]);
    chk("t2_ready_back", o_ready, 1'b1);
    cycle();
    chk("t2_retired", o_retired, 32'd6);

    // 3: step gating freezes everything
    i_ready = 1'b0; i_valid = 1'b1; i_payload = pl[6];
    cycle();
    i_payload = pl[7]; i_ready = 1'b1; i_step = 1'b0;
    r0 = o_retired;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_frozen_pl", o_payload, pl[6]);
      chk("t3_frozen_cnt", o_retired, r0);
      chk("t3_frozen_occ", o_occupancy, 2'd1);
    end
    i_step = 1'b1;
    cycle();
    chk("t3_resume_pl", o_payload, pl[7]);
    chk("t3_resume_cnt", o_retired, r0 + 32'd1);
    i_valid = 1'b0;
    cycle();
    chk("t3_drain_cnt", o_retired, r0 + 32'd2);

    // 4: flush while full
    i_ready = 1'b0;
    i_valid = 1'b1; i_payload = pl[0]; cycle();
    i_valid = 1'b1; i_payload = pl[1]; cycle();
    r0 = o_retired;
    i_flush = 1'b1; i_ready = 1'b1; i_valid = 1'b1; i_payload = pl[2];
    cycle();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("t4_valid", o_valid, 1'b0);
    chk("t4_wb_we", o_wb_we, 1'b0);
    chk("t4_retired", o_retired, r0);
    chk("t4_ready", o_ready, 1'b1);
    chk("t4_payload_kept", o_payload, pl[0]);
    cycle();

    // 5: halt retires while skid holds X
    pa = rand_payload(1'b1, 1'b1);
    px = rand_payload(1'b0, 1'b1);
    i_ready = 1'b0;
    i_valid = 1'b1; i_payload = pa; cycle();
    chk("t5_we_head", o_wb_we, 1'b1);
    i_valid = 1'b1; i_payload = px; cycle();
    i_valid = 1'b1; i_payload = pl[3]; i_ready = 1'b1;
    cycle();
    chk("t5_halted", o_halted, 1'b1);
    chk("t5_head_x", o_payload, px);
    chk("t5_ready0", o_ready, 1'b0);
    cycle();
    chk("t5_x_retired", o_occupancy, 2'd0);
    chk("t5_ready_hold", o_ready, 1'b0);
    cycle();
    chk("t5_still_halt", o_halted, 1'b1);
    i_reset = 1'b1;
    cycle();
    i_reset = 1'b0; i_valid = 1'b0;
    chk("t5_rst_halt", o_halted, 1'b0);
    chk("t5_rst_ready", o_ready, 1'b1);
    chk("t5_rst_cnt", o_retired, 32'd0);

    // Randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      if (!(i_valid && !m_acc)) begin
        i_valid   = ($urandom_range(0, 3) != 0);
        i_payload = rand_payload($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1);
      end
      i_step  = ($urandom_range(0, 7) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 31) == 0);
      i_reset = ($urandom_range(0, 63) == 0);
      cycle();
    end
    i_reset = 1'b0; i_flush = 1'b0; i_step = 1'b1; i_valid = 1'b0; i_ready = 1'b1;

    // 6: saturation of a 3-bit counter after 9 retirements
    i_reset = 1'b1; cycle(); i_reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      i_valid = 1'b1; i_payload = pl[k];
      cycle();
    end
    i_valid = 1'b0;
    cycle();
    chk("t6_sat", s_retired, 3'd7);
    chk("t6_wide", o_retired, 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
